// File: rtl/hd44780_ram_player_if.sv
// Signal bundle between the HD44780 RAM player, its command RAM, the host
// that starts playback, and the 4-bit LCD bus.
interface hd44780_ram_player_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [15:0]           rdata;
  logic                  busy;
  logic                  done;
  logic                  lcd_rs;
  logic                  lcd_rw;
  logic                  lcd_e;
  logic [3:0]            lcd_db;

  // The player masters the RAM read port and the LCD bus.
  modport master (
    input  start, start_addr, rdata,
    output raddr, busy, done, lcd_rs, lcd_rw, lcd_e, lcd_db
  );

  modport slave (
    output start, start_addr, rdata,
    input  raddr, busy, done, lcd_rs, lcd_rw, lcd_e, lcd_db
  );
endinterface

// File: rtl/hd44780_ram_player.sv
// Plays a list of 16-bit command words from RAM onto an HD44780 4-bit bus:
// each byte goes out as two E-strobed nibbles followed by a programmable delay.
module hd44780_ram_player #(
  parameter int ADDR_WIDTH  = 8,
  parameter int E_CYCLES    = 24,
  parameter int UNIT_CYCLES = 48
) (
  input logic                     clk,
  input logic                     rst_n,
  hd44780_ram_player_if.master    bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, NSETUP, NE, NGAP, DELAY
  } state_t;

  // One down-counter serves both the E timing and the post-byte delay.
  localparam int DELAY_MAX = 63 * UNIT_CYCLES;
  localparam int CNT_MAX   = (DELAY_MAX > E_CYCLES) ? DELAY_MAX : E_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] E_LOAD = CNT_W'(E_CYCLES - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  lo_nib_q, lo_nib_d;
  logic                  rs_q, rs_d;
  logic [3:0]            db_q, db_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  word_end;

  // NOTE: every register updates with non-blocking assignments so all of them
  // see the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      word_q   <= '0;
      cnt_q    <= '0;
      lo_nib_q <= 1'b0;
      rs_q     <= 1'b0;
      db_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      word_q   <= word_d;
      cnt_q    <= cnt_d;
      lo_nib_q <= lo_nib_d;
      rs_q     <= rs_d;
      db_q     <= db_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    word_d   = word_q;
    cnt_d    = cnt_q;
    lo_nib_d = lo_nib_q;
    rs_d     = rs_q;
    db_d     = db_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    word_end = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = bus.start_addr;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        // rdata is valid now; present the high nibble straight from it so
        // NSETUP already shows the new word.
        word_d   = bus.rdata;
        rs_d     = bus.rdata[14];
        db_d     = bus.rdata[7:4];
        lo_nib_d = 1'b0;
        state_d  = NSETUP;
      end
      NSETUP: begin
        cnt_d   = E_LOAD;
        state_d = NE;
      end
      NE: begin
        if (cnt_q == '0) begin
          cnt_d   = E_LOAD;
          state_d = NGAP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      NGAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!lo_nib_q) begin
          lo_nib_d = 1'b1;
          db_d     = word_q[3:0];
          state_d  = NSETUP;
        end else if (word_q[13:8] != '0) begin
          cnt_d   = CNT_W'(word_q[13:8]) * CNT_W'(UNIT_CYCLES) - CNT_W'(1);
          state_d = DELAY;
        end else begin
          word_end = 1'b1;
        end
      end
      DELAY: begin
        if (cnt_q == '0) word_end = 1'b1;
        else             cnt_d    = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (word_end) begin
      if (word_q[15]) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = FETCH;
      end
    end
  end

  // lcd_e decodes the state register so an async reset drops it at once.
  assign bus.raddr  = addr_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.lcd_rs = rs_q;
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_e  = (state_q == NE);
  assign bus.lcd_db = db_q;

endmodule

// File: tb/tb_hd44780_ram_player.sv
// Self-checking bench for hd44780_ram_player: a monitor pops expected
// (rs, nibble) pairs at each E strobe; scenario tasks check timing and addresses.
`timescale 1ns/1ps
module tb_hd44780_ram_player;

  localparam int AW = 8;
  localparam int E  = 24;
  localparam int U  = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hd44780_ram_player_if #(.ADDR_WIDTH(AW)) bus ();

  hd44780_ram_player #(
    .ADDR_WIDTH (AW),
    .E_CYCLES   (E),
    .UNIT_CYCLES(U)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Command RAM with registered read data.
  logic [15:0] mem [0:255];
  always @(posedge clk) bus.rdata <= mem[bus.raddr];

  int vectors     = 0;
  int miscompares = 0;

  logic [4:0]  exp_q [$];
  logic [7:0]  addr_log [$];
  int          done_cnt = 0;

  // Monitor state
  logic       e_prev = 1'b0;
  logic       prev_rs = 1'b0;
  logic [3:0] prev_db = '0;
  logic       hi_rs = 1'b0;
  logic [3:0] hi_db = '0;
  int         hi_cnt = 0;
  logic [4:0] exp_nib;

  function automatic void push_word(input logic [15:0] w);
    exp_q.push_back({w[14], w[7:4]});
    exp_q.push_back({w[14], w[3:0]});
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      e_prev  = 1'b0;
      hi_cnt  = 0;
      prev_rs = bus.lcd_rs;
      prev_db = bus.lcd_db;
    end else begin
      if (bus.lcd_e && !e_prev) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL nibble_unexpected: got rs=%0b db=%h, required no strobe", bus.lcd_rs, bus.lcd_db);
        end else begin
          exp_nib = exp_q.pop_front();
          if ({bus.lcd_rs, bus.lcd_db} !== exp_nib) begin
            miscompares++;
            $display("FAIL nibble: got rs=%0b db=%h, required rs=%0b db=%h",
                     bus.lcd_rs, bus.lcd_db, exp_nib[4], exp_nib[3:0]);
          end
          vectors++;
          if ({prev_rs, prev_db} !== exp_nib) begin
            miscompares++;
            $display("FAIL nibble_setup: got rs=%0b db=%h before E, required rs=%0b db=%h",
                     prev_rs, prev_db, exp_nib[4], exp_nib[3:0]);
          end
        end
        hi_cnt = 1;
        hi_rs  = bus.lcd_rs;
        hi_db  = bus.lcd_db;
      end else if (bus.lcd_e) begin
        hi_cnt++;
      end else if (e_prev) begin
        vectors++;
        if (hi_cnt != E) begin
          miscompares++;
          $display("FAIL e_width: got %0d cycles, required %0d", hi_cnt, E);
        end
        vectors++;
        if ({bus.lcd_rs, bus.lcd_db} !== {hi_rs, hi_db}) begin
          miscompares++;
          $display("FAIL e_hold: got rs=%0b db=%h at E fall, required rs=%0b db=%h",
                   bus.lcd_rs, bus.lcd_db, hi_rs, hi_db);
        end
      end
      if (bus.done) begin
        done_cnt++;
        vectors++;
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_at_done: got %0b, required 0", bus.busy);
        end
      end
      if (bus.busy && (addr_log.size() == 0 || addr_log[$] != bus.raddr))
        addr_log.push_back(bus.raddr);
      e_prev  = bus.lcd_e;
      prev_rs = bus.lcd_rs;
      prev_db = bus.lcd_db;
    end
  end

  // Releases reset (if held) together with a start pulse, then counts cycles
  // from FETCH entry to the done pulse; cycles = -1 if done never arrives.
  task automatic run_play(input logic [7:0] sa, input int restart_at, output int cycles);
    addr_log.delete();
    done_cnt = 0;
    cycles   = -1;
    @(negedge clk);
    rst_n          = 1'b1;
    bus.start_addr = sa;
    bus.start      = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (i == restart_at) begin
        bus.start_addr = 8'h50;
        bus.start      = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        cycles = i;
        break;
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start      = 1'b0;
    bus.start_addr = '0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.raddr, bus.busy, bus.done, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_db} !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got raddr=%h busy=%0b done=%0b e=%0b rs=%0b rw=%0b db=%h, required all 0",
               bus.raddr, bus.busy, bus.done, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_db);
    end
  endtask

  task automatic test_single();
    int cyc;
    mem[8'h10] = 16'h8128;
    push_word(16'h8128);
    run_play(8'h10, -1, cyc);
    vectors++;
    if (cyc != 148) begin
      miscompares++;
      $display("FAIL single_len: got %0d cycles, required 148", cyc);
    end
    vectors++;
    if (addr_log.size() != 1 || addr_log[0] !== 8'h10) begin
      miscompares++;
      $display("FAIL single_addr: got %p, required '{10}", addr_log);
    end
    vectors++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL single_end: got %0d nibbles left, %0d done, required 0 and 1", exp_q.size(), done_cnt);
    end
    vectors++;
    if (bus.lcd_rs !== 1'b0 || bus.lcd_db !== 4'h8) begin
      miscompares++;
      $display("FAIL idle_hold: got rs=%0b db=%h, required rs=0 db=8", bus.lcd_rs, bus.lcd_db);
    end
  endtask

  task automatic test_sequence();
    int cyc;
    mem[0] = 16'h0001; mem[1] = 16'h4048; mem[2] = 16'hC069; mem[3] = 16'h80AA;
    push_word(16'h0001); push_word(16'h4048); push_word(16'hC069);
    run_play(8'h00, -1, cyc);
    vectors++;
    if (cyc != 300) begin
      miscompares++;
      $display("FAIL seq_len: got %0d cycles, required 300", cyc);
    end
    vectors++;
    if (addr_log.size() != 3 || addr_log[0] !== 8'h00 || addr_log[1] !== 8'h01 || addr_log[2] !== 8'h02) begin
      miscompares++;
      $display("FAIL seq_addr: got %p, required '{0,1,2}", addr_log);
    end
    vectors++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL seq_end: got %0d nibbles left, %0d done, required 0 and 1", exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    mem[8'hFF] = 16'h0033; mem[8'h00] = 16'h8032;
    push_word(16'h0033); push_word(16'h8032);
    run_play(8'hFF, -1, cyc);
    vectors++;
    if (cyc != 200) begin
      miscompares++;
      $display("FAIL wrap_len: got %0d cycles, required 200", cyc);
    end
    vectors++;
    if (addr_log.size() != 2 || addr_log[0] !== 8'hFF || addr_log[1] !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap_addr: got %p, required '{ff,0}", addr_log);
    end
    vectors++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL wrap_end: got %0d nibbles left, %0d done, required 0 and 1", exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_ignored_start();
    int cyc;
    mem[8'h20] = 16'h0141; mem[8'h21] = 16'h4242; mem[8'h22] = 16'h8043;
    mem[8'h50] = 16'h80FF;
    push_word(16'h0141); push_word(16'h4242); push_word(16'h8043);
    run_play(8'h20, 50, cyc);
    vectors++;
    if (cyc != 148 + 196 + 100) begin
      miscompares++;
      $display("FAIL restart_len: got %0d cycles, required 444", cyc);
    end
    vectors++;
    if (addr_log.size() != 3 || addr_log[0] !== 8'h20 || addr_log[1] !== 8'h21 || addr_log[2] !== 8'h22) begin
      miscompares++;
      $display("FAIL restart_addr: got %p, required '{20,21,22}", addr_log);
    end
    repeat (20) @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0 || done_cnt != 1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_end: got %0d nibbles left, %0d done, busy=%0b, required 0, 1, 0",
               exp_q.size(), done_cnt, bus.busy);
    end
  endtask

  task automatic test_reset_mid_e();
    int  cyc;
    bit  seen_e = 1'b0;
    mem[8'h30] = 16'h8A5C;
    mem[8'h40] = 16'h8071;
    push_word(16'h8A5C);
    addr_log.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.start_addr = 8'h30;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.lcd_e) begin
        seen_e = 1'b1;
        break;
      end
    end
    vectors++;
    if (!seen_e) begin
      miscompares++;
      $display("FAIL mid_e_wait: got no E pulse in 200 cycles, required one");
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.lcd_e !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.raddr !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_e_reset: got e=%0b busy=%0b done=%0b raddr=%h, required 0 0 0 00",
               bus.lcd_e, bus.busy, bus.done, bus.raddr);
    end
    exp_q.delete();
    repeat (4) @(negedge clk);
    #1;
    vectors++;
    if (done_cnt != 0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_e_nodone: got %0d done pulses, required 0", done_cnt);
    end
    push_word(16'h8071);
    run_play(8'h40, -1, cyc);
    vectors++;
    if (cyc != 100 || addr_log.size() != 1 || addr_log[0] !== 8'h40) begin
      miscompares++;
      $display("FAIL mid_e_restart: got %0d cycles, addr %p, required 100 and '{40}", cyc, addr_log);
    end
    vectors++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL mid_e_end: got %0d nibbles left, %0d done, required 0 and 1", exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_zero_delay();
    int cyc;
    mem[8'h60] = 16'h8006;
    push_word(16'h8006);
    run_play(8'h60, -1, cyc);
    vectors++;
    if (cyc != 100) begin
      miscompares++;
      $display("FAIL zero_delay_len: got %0d cycles, required 100", cyc);
    end
    vectors++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL zero_delay_end: got %0d nibbles left, %0d done, required 0 and 1", exp_q.size(), done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000;
    test_reset();
    test_single();
    test_sequence();
    test_wrap();
    test_ignored_start();
    test_reset_mid_e();
    test_zero_delay();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion by 1 ms, required completion");
    $fatal(1, "simulation timeout");
  end

endmodule
